// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: main control FSM of the multicycle MIPS-style core with req/ready memory handshake.
// Define ILLEGAL_TRAP_EN to send illegal opcodes to FAULT instead of retiring them as NOPs.
module multicycle_control_unit #(
  parameter logic [4:0] ALU_ADD_FUNC = 5'b00001,
  parameter logic [4:0] ALU_SUB_FUNC = 5'b00010,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] IRType,
  input  logic [4:0] IRFunc,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] WBSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUType,
  output logic [4:0] ALUFunc,
  output logic       InstrDone,
  output logic       Fault,
  output logic [2:0] State
);
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_FAULT = 3'd7
  } state_t;
  state_t state, state_next;
  logic [7:0] cnt;
  logic is_r, is_i, is_j, is_s, i_alu, i_lw, i_sw, i_beq, j_jal, legal, waiting, timeout;
  assign is_r  = IRType == 2'b00;
  assign is_i  = IRType == 2'b01;
  assign is_j  = IRType == 2'b10;
  assign is_s  = IRType == 2'b11;
  assign i_alu = is_i && IRFunc <= 5'd1;
  assign i_lw  = is_i && IRFunc == 5'd2;
  assign i_sw  = is_i && IRFunc == 5'd3;
  assign i_beq = is_i && IRFunc == 5'd4;
  assign j_jal = is_j && IRFunc == 5'd1;
  assign legal = (is_r && IRFunc <= 5'd3) || (is_s && IRFunc <= 5'd1) ||
                 (is_i && IRFunc <= 5'd4) || (is_j && IRFunc <= 5'd1);
  // Counter only runs while a memory request is stalled, so it is already clear on entering FETCH/MEM.
  assign waiting = (state == S_FETCH || state == S_MEM) && !MemReady;
  assign timeout = MEM_TIMEOUT != 0 && waiting && cnt == TO_LAST;
  assign Fault   = state == S_FAULT;
  assign State   = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FETCH;
      cnt <= '0;
    end else begin
      state <= state_next;
      cnt <= waiting ? cnt + 8'd1 : '0;
    end
  // Strobes are gated by rst_n so an asserted reset drops any request immediately.
  always_comb begin
    state_next = state;
    PCWrite = 1'b0;
    PCSrc = 2'b00;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    WBSrc = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUType = 2'b00;
    ALUFunc = ALU_ADD_FUNC;
    InstrDone = 1'b0;
    if (rst_n)
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
          state_next = timeout ? S_FAULT : MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          state_next = S_EXEC;
        end
        S_EXEC:
          if (!legal) begin
            InstrDone = !TRAP;
            state_next = TRAP ? S_FAULT : S_FETCH;
          end else if (is_r || is_s) begin
            ALUSrcA = 1'b1;
            ALUType = IRType;
            ALUFunc = IRFunc;
            state_next = S_WB;
          end else if (is_i) begin
            ALUSrcA = 1'b1;
            ALUSrcB = i_beq ? 2'b00 : 2'b10;
            ALUFunc = i_alu ? IRFunc : i_beq ? ALU_SUB_FUNC : ALU_ADD_FUNC;
            PCWrite = i_beq && Zero;
            PCSrc = i_beq ? 2'b01 : 2'b00;
            InstrDone = i_beq;
            state_next = i_beq ? S_FETCH : i_alu ? S_WB : S_MEM;
          end else begin
            PCWrite = 1'b1;
            PCSrc = 2'b10;
            RegWrite = j_jal;
            WBSrc = j_jal ? 2'b10 : 2'b00;
            InstrDone = 1'b1;
            state_next = S_FETCH;
          end
        S_MEM: begin
          IorD = 1'b1;
          MemRead = i_lw;
          MemWrite = i_sw;
          InstrDone = i_sw && MemReady;
          state_next = timeout ? S_FAULT : !MemReady ? S_MEM : i_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          RegWrite = 1'b1;
          WBSrc = i_lw ? 2'b01 : 2'b00;
          InstrDone = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = state;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream with scoreboard, plus timeout, reset and illegal-op cases.
module tb_multicycle_control_unit;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int ADD = 1, SUB = 2;
  typedef struct {int t, f, z;} ins_t;
  typedef struct {int cyc, pcw, pcsrc, rw, wb, frd, drd, dwr, iod, alu, src, st; bit mem, ill;} exp_t;
  logic clk = 1'b0, rst_n = 1'b1, Zero = 1'b0, MemReady = 1'b0;
  logic [1:0] IRType = '0;
  logic [4:0] IRFunc = '0;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, InstrDone, Fault;
  logic [1:0] PCSrc, WBSrc, ALUSrcB, ALUType;
  logic [4:0] ALUFunc;
  logic [2:0] State;
  int tests = 0, fails = 0;
  bit run = 1'b0, busy = 1'b0;
  int wcnt = 0;
  ins_t ins;
  ins_t instr_q[$];
  int wait_q[$];
  exp_t exp_q[$];
  int cyc, pcw, pcsrc, rw, wb, irw, frd, drd, dwr, iod, decb, alu, src;

  multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .IRType(IRType), .IRFunc(IRFunc), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .WBSrc(WBSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUType(ALUType), .ALUFunc(ALUFunc), .InstrDone(InstrDone), .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_acc();
    cyc = 0; pcw = 0; pcsrc = -1; rw = 0; wb = -1; irw = 0;
    frd = 0; drd = 0; dwr = 0; iod = 0; decb = -1; alu = -1; src = -1;
  endtask

  // Instruction-level reference: CPI, side-effect counts and ALU setup from the instruction class.
  function automatic exp_t model(int t, int f, int z, int fw, int mw);
    exp_t e;
    bit r, ai, lw, sw, beq, j, jal;
    r   = (t == 0 && f <= 3) || (t == 3 && f <= 1);
    ai  = t == 1 && f <= 1;
    lw  = t == 1 && f == 2;
    sw  = t == 1 && f == 3;
    beq = t == 1 && f == 4;
    j   = t == 2 && f == 0;
    jal = t == 2 && f == 1;
    e.ill = !(r || ai || lw || sw || beq || j || jal);
    e.mem = lw || sw;
    e.cyc = ((r || ai || sw) ? 4 : lw ? 5 : 3) + fw + (e.mem ? mw : 0);
    e.pcw = 1 + int'(beq && z != 0) + int'(j || jal);
    e.pcsrc = (j || jal) ? 2 : (beq && z != 0) ? 1 : 0;
    e.rw = int'(r || ai || lw || jal);
    e.wb = lw ? 1 : jal ? 2 : (r || ai) ? 0 : -1;
    e.frd = fw + 1;
    e.drd = lw ? mw + 1 : 0;
    e.dwr = sw ? mw + 1 : 0;
    e.iod = e.mem ? mw + 1 : 0;
    e.alu = r ? t * 32 + f : ai ? f : e.mem ? ADD : beq ? SUB : -1;
    e.src = (r || beq) ? 4 : (ai || e.mem) ? 6 : -1;
    e.st = (r || ai || lw) ? 4 : sw ? 3 : 2;
    return e;
  endfunction

  // Memory/IR responder: new IR presented at the start of each fetch; wait counts from wait_q.
  initial forever begin
    @(negedge clk);
    #1;
    if (run) begin
      if (MemRead || MemWrite) begin
        if (!busy) begin
          if (IorD && wait_q.size() > 0) begin
            wcnt = wait_q.pop_front();
            busy = 1'b1;
          end else if (!IorD && instr_q.size() > 0) begin
            ins = instr_q.pop_front();
            IRType = 2'(ins.t);
            IRFunc = 5'(ins.f);
            Zero = ins.z[0];
            wcnt = wait_q.pop_front();
            busy = 1'b1;
          end
        end
        if (busy && wcnt > 0) begin
          MemReady = 1'b0;
          wcnt--;
        end else if (busy) begin
          MemReady = 1'b1;
          busy = 1'b0;
        end else MemReady = 1'b0;
      end else MemReady = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: accumulates per-instruction activity and scores it when InstrDone pulses.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (run && rst_n) begin
      cyc++;
      if (PCWrite) begin pcw++; pcsrc = int'(PCSrc); end
      if (RegWrite) begin rw++; wb = int'(WBSrc); end
      irw += int'(IRWrite);
      frd += int'(MemRead && !IorD);
      drd += int'(MemRead && IorD);
      dwr += int'(MemWrite);
      iod += int'(IorD);
      if (State == 3'd1) decb = int'(ALUSrcB);
      if (State == 3'd2) begin
        alu = int'(ALUType) * 32 + int'(ALUFunc);
        src = int'(ALUSrcA) * 4 + int'(ALUSrcB);
      end
      if (InstrDone) begin
        check("has_expect", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cycles", cyc, e.cyc);
          check("pc_writes", pcw, e.pcw);
          check("pc_src", pcsrc, e.pcsrc);
          check("reg_writes", rw, e.rw);
          check("wb_src", wb, e.wb);
          check("ir_writes", irw, 1);
          check("fetch_reads", frd, e.frd);
          check("data_reads", drd, e.drd);
          check("data_writes", dwr, e.dwr);
          check("iord_cycles", iod, e.iod);
          check("decode_srcb", decb, 3);
          check("done_state", int'(State), e.st);
          check("no_fault", int'(Fault), 0);
          if (e.alu >= 0) check("exec_alu", alu, e.alu);
          if (e.src >= 0) check("exec_src", src, e.src);
        end
        clear_acc();
      end
    end
  end

  initial begin
    ins_t i;
    exp_t e;
    int fw, mw;
    clear_acc();
    #3 rst_n = 1'b0;
    #1;
    check("rst_state", int'(State), 0);
    check("rst_memread", int'(MemRead), 0);
    check("rst_memwrite", int'(MemWrite), 0);
    check("rst_pcwrite", int'(PCWrite), 0);
    check("rst_irwrite", int'(IRWrite), 0);
    check("rst_regwrite", int'(RegWrite), 0);
    check("rst_done", int'(InstrDone), 0);
    check("rst_fault", int'(Fault), 0);
    check("rst_alutype", int'(ALUType), 0);
    check("rst_alufunc", int'(ALUFunc), ADD);
    for (int n = 0; n < 250; n++) begin
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      do begin
        i.t = $urandom_range(0, 3);
        i.f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
        i.z = $urandom_range(0, 1);
        e = model(i.t, i.f, i.z, fw, mw);
      end while (TRAP && e.ill);
      instr_q.push_back(i);
      wait_q.push_back(fw);
      if (e.mem) wait_q.push_back(mw);
      exp_q.push_back(e);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 30000 && exp_q.size() != 0; c++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    run = 1'b0;
    // Memory timeout in FETCH, sticky fault, async reset recovery.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    MemReady = 1'b0;
    #1;
    check("async_memread", int'(MemRead), 0);
    check("async_memwrite", int'(MemWrite), 0);
    check("async_state", int'(State), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("to_wait_state", int'(State), 0);
    check("to_wait_fault", int'(Fault), 0);
    @(negedge clk);
    #2;
    check("to_state", int'(State), 7);
    check("to_fault", int'(Fault), 1);
    check("to_memread", int'(MemRead), 0);
    MemReady = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("sticky_fault", int'(Fault), 1);
    check("sticky_state", int'(State), 7);
    rst_n = 1'b0;
    #1;
    check("rst_clr_fault", int'(Fault), 0);
    check("rst_clr_state", int'(State), 0);
    // Illegal R func 5.
    IRType = 2'b00;
    IRFunc = 5'd5;
    Zero = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ill_irwrite", int'(IRWrite), 1);
    @(negedge clk);
    #2 check("ill_decode", int'(State), 1);
    @(negedge clk);
    #2;
    check("ill_exec", int'(State), 2);
    check("ill_done", int'(InstrDone), int'(!TRAP));
    check("ill_regwrite", int'(RegWrite), 0);
    check("ill_pcwrite", int'(PCWrite), 0);
    check("ill_memwrite", int'(MemWrite), 0);
    @(negedge clk);
    #2;
    check("ill_next", int'(State), TRAP ? 7 : 0);
    check("ill_fault", int'(Fault), int'(TRAP));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
